muldiv_controller: RTL and testbench
====================================

MULDIV_CONTROLLER -- requirements
Module: muldiv_controller

Interface
REQ-001 Parameter WIDTH, default 32, operand and HI/LO width.
REQ-002 Parameter ITER, default 32, number of RUN iterations; always equals WIDTH.
REQ-003 clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-005 start  input  1  EX-stage request to launch a HI/LO operation this cycle.
REQ-006 funct  input  6  operation select: 011000 MULT, 011001 MULTU, 011010 DIV, 011011 DIVU.
REQ-007 rs_val  input  WIDTH  multiplicand / dividend.
REQ-008 rt_val  input  WIDTH  multiplier / divisor.
REQ-009 mfhi_req, mflo_req  input  1 each  ID/EX instruction reads HI / LO.
REQ-010 hi, lo  output  WIDTH each  architectural HI and LO registers.
REQ-011 busy  output  1  operation in progress (state RUN or ADJUST).
REQ-012 done  output  1  single-cycle pulse when hi/lo take a new result.
REQ-013 stall  output  1  holds IF/ID/EX pipeline registers.

Function
REQ-014 States SHALL be IDLE, RUN and ADJUST.
REQ-015 In IDLE, start=1 with a legal funct SHALL latch operands, op type and signedness, clear the iteration counter and go to RUN.
REQ-016 In IDLE, start=1 with any other funct SHALL be ignored; the state stays IDLE and hi/lo are unchanged.
REQ-017 Signed ops SHALL convert operands to magnitudes at launch and record result signs: product sign = sign(rs)^sign(rt); quotient sign likewise; remainder sign = sign(rs).
REQ-018 Each RUN cycle SHALL perform one shift-add (multiply) or one restoring shift-subtract (divide) step and increment the counter.
REQ-019 RUN SHALL go to ADJUST after exactly ITER cycles.
REQ-020 ADJUST SHALL apply the sign correction (two's-complement negation), write hi/lo, pulse done and return to IDLE, all in one cycle.
REQ-021 Latency: done SHALL be high in cycle N+ITER+2, where cycle N is the one in which start is sampled (34 cycles after start for WIDTH=32); hi/lo change on the same edge.
REQ-022 Multiply results: hi = upper WIDTH bits, lo = lower WIDTH bits of the 2*WIDTH product.
REQ-023 Divide results: lo = quotient, hi = remainder; signed division truncates toward zero.
REQ-024 Divisor zero SHALL give lo = all-ones and hi = the dividend, with normal latency.
REQ-025 Signed 0x80000000 / 0xFFFFFFFF SHALL give lo = 0x80000000 and hi = 0.
REQ-026 stall = busy AND (start OR mfhi_req OR mflo_req), combinational.
REQ-027 start while busy SHALL NOT be accepted; it stalls until the cycle after done, then is accepted from IDLE.
REQ-028 mfhi_req/mflo_req while IDLE SHALL NOT stall, including the cycle in which done is high.
REQ-029 hi/lo SHALL hold their value at all times except the ADJUST edge.

Reset
REQ-030 reset=1 SHALL force state IDLE, hi=0, lo=0, busy=0, done=0, counter=0 and all operand registers to 0, independent of clk.
REQ-031 Reset during RUN or ADJUST SHALL abandon the operation; no done pulse and no hi/lo update follow.
REQ-032 The first start after reset deasserts SHALL be accepted normally.

Structure
REQ-033 A shared package SHALL hold the funct codes for MULT/MULTU/DIV/DIVU/MFHI/MFLO, the state encoding and the WIDTH default.
REQ-034 The per-iteration arithmetic SHALL be a sub-module muldiv_step (shift-add / shift-subtract, combinational); muldiv_controller owns the FSM, counter, sign handling and HI/LO.

Verification
REQ-035 MULT rs=0xFFFFFFFD (-3), rt=7 -> done at cycle +34; hi=0xFFFFFFFF, lo=0xFFFFFFEB.
REQ-036 DIVU rs=100, rt=7 -> lo=14, hi=2; DIV rs=0xFFFFFFF9 (-7), rt=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
REQ-037 DIV rs=5, rt=0 -> lo=0xFFFFFFFF, hi=5; DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-038 MULTU 0xFFFFFFFF*0xFFFFFFFF, then mflo_req at cycle +5 -> stall=1 through cycle +33, stall=0 at done; hi=0xFFFFFFFE, lo=0x00000001.
REQ-039 Back-to-back start held high -> the second op is accepted the cycle after the first done; one done pulse per op.
REQ-040 reset at cycle +10 of a MULT -> busy=0, hi=lo=0 immediately; no done pulse within the following 40 cycles.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: funct codes,
// FSM state encoding and the default datapath width.
package muldiv_pkg;

   localparam int MULDIV_WIDTH = 32;

   localparam logic [5:0] FUNCT_MFHI  = 6'b010000;
   localparam logic [5:0] FUNCT_MFLO  = 6'b010010;
   localparam logic [5:0] FUNCT_MULT  = 6'b011000;
   localparam logic [5:0] FUNCT_MULTU = 6'b011001;
   localparam logic [5:0] FUNCT_DIV   = 6'b011010;
   localparam logic [5:0] FUNCT_DIVU  = 6'b011011;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RUN    = 2'd1,
      ST_ADJUST = 2'd2
   } state_e;

   // True for the four operations that launch the iterative unit.
   function automatic logic is_hilo_op(input logic [5:0] f);
      return (f == FUNCT_MULT) || (f == FUNCT_MULTU) ||
             (f == FUNCT_DIV)  || (f == FUNCT_DIVU);
   endfunction

   function automatic logic is_signed_op(input logic [5:0] f);
      return (f == FUNCT_MULT) || (f == FUNCT_DIV);
   endfunction

   function automatic logic is_div_op(input logic [5:0] f);
      return (f == FUNCT_DIV) || (f == FUNCT_DIVU);
   endfunction

   // True for instructions that read HI or LO.
   function automatic logic is_move_op(input logic [5:0] f);
      return (f == FUNCT_MFHI) || (f == FUNCT_MFLO);
   endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the unsigned datapath.
// Multiply: acc:quo is the running product, quo[0] is the next multiplier
// bit, opd is the multiplicand; add-then-shift-right.
// Divide: acc is the partial remainder, quo holds the dividend bits still
// to consume (MSB first) and collects quotient bits; opd is the divisor.
module muldiv_step
   import muldiv_pkg::*;
#(
   parameter int WIDTH = MULDIV_WIDTH
) (
   input  logic             is_div_i,
   input  logic [WIDTH-1:0] acc_i,
   input  logic [WIDTH-1:0] quo_i,
   input  logic [WIDTH-1:0] opd_i,
   output logic [WIDTH-1:0] acc_o,
   output logic [WIDTH-1:0] quo_o
);

   logic [WIDTH:0] sum;
   logic [WIDTH:0] shifted;

   // Single shift-add or restoring shift-subtract step.
   always_comb begin
      sum     = '0;
      shifted = '0;
      acc_o   = acc_i;
      quo_o   = quo_i;
      if (is_div_i) begin
         shifted = {acc_i, quo_i[WIDTH-1]};
         if (shifted >= {1'b0, opd_i}) begin
            // Difference is below the divisor, so it fits in WIDTH bits.
            sum   = shifted - {1'b0, opd_i};
            acc_o = sum[WIDTH-1:0];
            quo_o = {quo_i[WIDTH-2:0], 1'b1};
         end else begin
            acc_o = shifted[WIDTH-1:0];
            quo_o = {quo_i[WIDTH-2:0], 1'b0};
         end
      end else begin
         sum   = {1'b0, acc_i} + (quo_i[0] ? {1'b0, opd_i} : '0);
         acc_o = sum[WIDTH:1];
         quo_o = {sum[0], quo_i[WIDTH-1:1]};
      end
   end

endmodule

// File: rtl/muldiv_controller.sv
// Iterative HI/LO multiply/divide controller. Operands are converted to
// magnitudes at launch, ITER unsigned steps run in muldiv_step, and the
// ADJUST cycle applies sign correction and writes HI/LO.
// Handshake: start is taken only in IDLE with a legal funct; while busy,
// start/mfhi_req/mflo_req raise stall and the requester must hold its
// request until stall drops (done is high in an IDLE cycle, so no stall).
module muldiv_controller
   import muldiv_pkg::*;
#(
   parameter int WIDTH = MULDIV_WIDTH,
   parameter int ITER  = WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [5:0]       funct,
   input  logic [WIDTH-1:0] rs_val,
   input  logic [WIDTH-1:0] rt_val,
   input  logic             mfhi_req,
   input  logic             mflo_req,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             busy,
   output logic             done,
   output logic             stall,
   output logic [1:0]       dbg_state
);

   localparam int             CW       = $clog2(ITER + 1);
   localparam logic [CW-1:0]  CNT_LAST = CW'(ITER - 1);

   state_e             state_q, state_d;
   logic [CW-1:0]      cnt_q;
   logic [WIDTH-1:0]   acc_q, quo_q, opd_q;
   logic [WIDTH-1:0]   acc_step, quo_step;
   logic [WIDTH-1:0]   hi_q, lo_q;
   logic               is_div_q, neg_res_q, neg_rem_q, divz_q, done_q;
   logic               launch, rs_neg, rt_neg;
   logic [WIDTH-1:0]   rs_mag, rt_mag;
   logic [2*WIDTH-1:0] prod_raw, prod_fix;
   logic [WIDTH-1:0]   quo_fix, rem_fix;

   assign launch = (state_q == ST_IDLE) && start && is_hilo_op(funct);
   assign rs_neg = is_signed_op(funct) && rs_val[WIDTH-1];
   assign rt_neg = is_signed_op(funct) && rt_val[WIDTH-1];
   assign rs_mag = rs_neg ? -rs_val : rs_val;
   assign rt_mag = rt_neg ? -rt_val : rt_val;

   muldiv_step #(.WIDTH(WIDTH)) u_step (
      .is_div_i (is_div_q),
      .acc_i    (acc_q),
      .quo_i    (quo_q),
      .opd_i    (opd_q),
      .acc_o    (acc_step),
      .quo_o    (quo_step)
   );

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   // Next-state: launch, count ITER steps, one ADJUST cycle.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:   if (launch) state_d = ST_RUN;
         ST_RUN:    if (cnt_q == CNT_LAST) state_d = ST_ADJUST;
         ST_ADJUST: state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   // FSM outputs: busy while the unit owns HI/LO, stall for dependent requests.
   always_comb begin
      busy      = (state_q == ST_RUN) || (state_q == ST_ADJUST);
      stall     = busy && (start || mfhi_req || mflo_req);
      dbg_state = state_q;
   end

   // Operand capture at launch, one datapath step per RUN cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q     <= '0;
         acc_q     <= '0;
         quo_q     <= '0;
         opd_q     <= '0;
         is_div_q  <= 1'b0;
         neg_res_q <= 1'b0;
         neg_rem_q <= 1'b0;
         divz_q    <= 1'b0;
      end else if (launch) begin
         cnt_q     <= '0;
         acc_q     <= '0;
         is_div_q  <= is_div_op(funct);
         neg_res_q <= rs_neg ^ rt_neg;
         neg_rem_q <= rs_neg;
         divz_q    <= (rt_val == '0);
         if (is_div_op(funct)) begin
            quo_q <= rs_mag;
            opd_q <= rt_mag;
         end else begin
            quo_q <= rt_mag;
            opd_q <= rs_mag;
         end
      end else if (state_q == ST_RUN) begin
         cnt_q <= cnt_q + 1'b1;
         acc_q <= acc_step;
         quo_q <= quo_step;
      end
   end

   // Sign correction of the unsigned results; divide-by-zero forces LO to
   // all ones while HI naturally ends up as the original dividend.
   always_comb begin
      prod_raw = {acc_q, quo_q};
      prod_fix = neg_res_q ? -prod_raw : prod_raw;
      quo_fix  = divz_q ? '1 : (neg_res_q ? -quo_q : quo_q);
      rem_fix  = neg_rem_q ? -acc_q : acc_q;
   end

   // HI/LO write and done pulse on the ADJUST edge only.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hi_q   <= '0;
         lo_q   <= '0;
         done_q <= 1'b0;
      end else begin
         done_q <= (state_q == ST_ADJUST);
         if (state_q == ST_ADJUST) begin
            if (is_div_q) begin
               hi_q <= rem_fix;
               lo_q <= quo_fix;
            end else begin
               hi_q <= prod_fix[2*WIDTH-1:WIDTH];
               lo_q <= prod_fix[WIDTH-1:0];
            end
         end
      end
   end

   assign hi   = hi_q;
   assign lo   = lo_q;
   assign done = done_q;

endmodule

// File: tb/tb_muldiv_controller.sv
// Bench for muldiv_controller (WIDTH = ITER = 32). An arithmetic reference
// model predicts HI/LO and the busy/done timeline; a compare process checks
// every cycle, and directed vectors pin literal results and latencies.
module tb_muldiv_controller;

   localparam int ITER = 32;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic [5:0]  funct = 6'h0;
   logic [31:0] rs_val = 32'h0;
   logic [31:0] rt_val = 32'h0;
   logic        mfhi_req = 1'b0;
   logic        mflo_req = 1'b0;
   logic [31:0] hi, lo;
   logic        busy, done, stall;
   logic [1:0]  dbg_state;

   int n_checks = 0;
   int n_errors = 0;
   logic chk_en = 1'b0;

   muldiv_controller dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .funct     (funct),
      .rs_val    (rs_val),
      .rt_val    (rt_val),
      .mfhi_req  (mfhi_req),
      .mflo_req  (mflo_req),
      .hi        (hi),
      .lo        (lo),
      .busy      (busy),
      .done      (done),
      .stall     (stall),
      .dbg_state (dbg_state)
   );

   // clock
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic legal(input logic [5:0] f);
      return (f >= 6'h18) && (f <= 6'h1b);
   endfunction

   // Reference result {hi, lo} from plain arithmetic.
   function automatic logic [63:0] model_result(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
      longint sa, sb, q, r;
      logic [63:0] res;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      res = '0;
      case (f)
         6'h18: res = 64'(sa * sb);
         6'h19: res = {32'h0, a} * {32'h0, b};
         6'h1a: begin
            if (b == 0) res = {a, 32'hFFFFFFFF};
            else begin
               q = sa / sb;
               r = sa % sb;
               res = {r[31:0], q[31:0]};
            end
         end
         6'h1b: begin
            if (b == 0) res = {a, 32'hFFFFFFFF};
            else res = {a % b, a / b};
         end
         default: res = '0;
      endcase
      return res;
   endfunction

   // Timeline model: an accepted op keeps the unit busy ITER+1 cycles,
   // then done is high for one cycle with the new HI/LO.
   int          m_left = 0;
   logic        m_done = 1'b0;
   logic [31:0] m_hi = 32'h0, m_lo = 32'h0;
   logic [63:0] m_pend = 64'h0;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_left <= 0;
         m_done <= 1'b0;
         m_hi   <= 32'h0;
         m_lo   <= 32'h0;
      end else begin
         m_done <= 1'b0;
         if (m_left > 0) begin
            m_left <= m_left - 1;
            if (m_left == 1) begin
               m_hi   <= m_pend[63:32];
               m_lo   <= m_pend[31:0];
               m_done <= 1'b1;
            end
         end else if (start && legal(funct)) begin
            m_pend <= model_result(funct, rs_val, rt_val);
            m_left <= ITER + 1;
         end
      end
   end

   // Per-cycle compare against the model.
   always @(negedge clk) begin
      if (chk_en) begin
         check("busy",  {63'h0, busy},  {63'h0, (m_left > 0)});
         check("done",  {63'h0, done},  {63'h0, m_done});
         check("stall", {63'h0, stall}, {63'h0, (m_left > 0) && (start || mfhi_req || mflo_req)});
         check("hi",    {32'h0, hi},    {32'h0, m_hi});
         check("lo",    {32'h0, lo},    {32'h0, m_lo});
      end
   end

   // Launch one op, optionally raise mflo_req from cycle mf_from on, and
   // check latency and literal HI/LO.
   task automatic run_op(input string name, input logic [5:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el,
                         input int mf_from);
      int lat;
      lat = 0;
      @(posedge clk); #1;
      start = 1'b1; funct = f; rs_val = a; rt_val = b;
      @(posedge clk); #1;
      start = 1'b0;
      for (int cyc = 1; cyc <= 60; cyc++) begin
         mflo_req = (mf_from != 0) && (cyc >= mf_from);
         @(negedge clk);
         if (mf_from != 0 && cyc >= mf_from)
            check({name, " stall"}, {63'h0, stall}, {63'h0, (cyc < ITER + 2)});
         if (done) begin
            lat = cyc;
            break;
         end
         @(posedge clk); #1;
      end
      check({name, " latency"}, 64'(lat), 64'(ITER + 2));
      check({name, " hi"}, {32'h0, hi}, {32'h0, eh});
      check({name, " lo"}, {32'h0, lo}, {32'h0, el});
      @(posedge clk); #1;
      mflo_req = 1'b0;
   endtask

   initial begin
      int dones, first, second, cnt;

      // reset
      #1 reset = 1'b1;
      #1;
      check("reset hi",    {32'h0, hi}, 64'h0);
      check("reset lo",    {32'h0, lo}, 64'h0);
      check("reset busy",  {63'h0, busy}, 64'h0);
      check("reset done",  {63'h0, done}, 64'h0);
      check("reset state", {62'h0, dbg_state}, 64'h0);
      repeat (2) @(posedge clk);
      #3 reset = 1'b0;
      chk_en = 1'b1;

      // directed arithmetic vectors
      run_op("mult -3*7",     6'h18, 32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, 0);
      run_op("divu 100/7",    6'h1b, 32'd100,      32'd7,        32'd2,        32'd14,       0);
      run_op("div -7/2",      6'h1a, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 0);
      run_op("div 5/0",       6'h1a, 32'd5,        32'd0,        32'd5,        32'hFFFFFFFF, 0);
      run_op("div min/-1",    6'h1a, 32'h80000000, 32'hFFFFFFFF, 32'h0,        32'h80000000, 0);
      run_op("div 7/-2",      6'h1a, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 0);
      run_op("divu max/16",   6'h1b, 32'hFFFFFFFF, 32'h10,       32'hF,        32'h0FFFFFFF, 0);
      run_op("multu small",   6'h19, 32'h12345678, 32'h10,       32'h1,        32'h23456780, 0);
      run_op("div -5/0",      6'h1a, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 32'hFFFFFFFF, 0);
      run_op("multu max*max", 6'h19, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 5);

      // illegal funct is ignored
      @(posedge clk); #1;
      start = 1'b1; funct = 6'b010000; rs_val = 32'd9; rt_val = 32'd9;
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      check("illegal busy", {63'h0, busy}, 64'h0);
      check("illegal hi", {32'h0, hi}, 64'hFFFFFFFE);
      check("illegal lo", {32'h0, lo}, 64'h00000001);

      // back-to-back: start held, operands change while stalled
      @(posedge clk); #1;
      start = 1'b1; funct = 6'h18; rs_val = 32'hFFFFFFFD; rt_val = 32'd7;
      dones = 0; first = 0; second = 0;
      for (int cyc = 1; cyc <= 120; cyc++) begin
         @(posedge clk); #1;
         if (cyc == 2) begin
            funct = 6'h1b; rs_val = 32'd100; rt_val = 32'd7;
         end
         if (cyc == 35) start = 1'b0;
         @(negedge clk);
         if (done) begin
            dones++;
            if (dones == 1) begin
               first = cyc;
               check("b2b first hi", {32'h0, hi}, 64'hFFFFFFFF);
               check("b2b first lo", {32'h0, lo}, 64'hFFFFFFEB);
            end else second = cyc;
         end
      end
      check("b2b done count", 64'(dones), 64'd2);
      check("b2b first at",   64'(first), 64'd34);
      check("b2b second at",  64'(second), 64'd68);
      check("b2b second hi",  {32'h0, hi}, 64'd2);
      check("b2b second lo",  {32'h0, lo}, 64'd14);

      // reset in the middle of a MULT
      @(posedge clk); #1;
      start = 1'b1; funct = 6'h18; rs_val = 32'hFFFFFFFD; rt_val = 32'd7;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (9) @(posedge clk);
      #3 reset = 1'b1;
      #1;
      check("midreset busy", {63'h0, busy}, 64'h0);
      check("midreset hi",   {32'h0, hi}, 64'h0);
      check("midreset lo",   {32'h0, lo}, 64'h0);
      check("midreset done", {63'h0, done}, 64'h0);
      @(posedge clk); #3 reset = 1'b0;
      cnt = 0;
      repeat (40) begin
         @(negedge clk);
         if (done) cnt++;
      end
      check("midreset no done", 64'(cnt), 64'h0);
      check("midreset hi hold", {32'h0, hi}, 64'h0);

      // first op after reset
      run_op("post-reset divu", 6'h1b, 32'd100, 32'd7, 32'd2, 32'd14, 0);

      repeat (2) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
